// File: rtl/stopwatch_timer.sv
// Stopwatch control stage: debounced start/stop, lap and clear buttons, a run/stop/lap FSM
// and a prescaled 2-digit BCD count with a registered display output.
module stopwatch_timer #(
  parameter int unsigned TICK_DIV        = 1200000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [7:0] dout,
  output logic       running,
  output logic       lap_hold
);

  typedef enum logic [1:0] {StCleared, StRunning, StStopped} state_e;

  localparam int unsigned PsW = $clog2(TICK_DIV);
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(TICK_DIV - 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  // Button lanes: [0] start_stop, [1] lap, [2] clear
  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     level_q, level_d, level_prev_q;
  logic [2:0]     press;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  state_e         state_q, state_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic [7:0]     count_q, count_d;
  logic [7:0]     lap_reg_q, lap_reg_d;
  logic [7:0]     dout_d;
  logic           lap_hold_q, lap_hold_d;
  logic           tick;

  assign btn_raw  = {btn_clear, btn_lap, btn_start_stop};
  assign press    = level_q & ~level_prev_q;
  assign lap_hold = lap_hold_q;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lap_reg_d  = lap_reg_q;
    lap_hold_d = lap_hold_q;
    tick       = (state_q == StRunning) && (presc_q == PsMax);

    if (tick) begin
      count_d = bcd_inc(count_q);
    end

    // Priority clear > start_stop > lap; losers in the same cycle are dropped
    if (press[2]) begin
      state_d    = StCleared;
      count_d    = 8'h00;
      lap_hold_d = 1'b0;
    end else if (press[0]) begin
      case (state_q)
        StCleared: state_d = StRunning;
        StRunning: state_d = StStopped;
        StStopped: state_d = StRunning;
        default:   state_d = StCleared;
      endcase
    end else if (press[1]) begin
      if ((state_q == StRunning) && !lap_hold_q) begin
        lap_reg_d  = count_q;
        lap_hold_d = 1'b1;
      end else begin
        lap_hold_d = 1'b0;
      end
    end

    if ((state_q == StRunning) && (state_d == StRunning)) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end else begin
      presc_d = '0;
    end

    dout_d = lap_hold_d ? lap_reg_d : count_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q      <= StCleared;
      presc_q      <= '0;
      count_q      <= 8'h00;
      lap_reg_q    <= 8'h00;
      lap_hold_q   <= 1'b0;
      dout         <= 8'h00;
      running      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q      <= state_d;
      presc_q      <= presc_d;
      count_q      <= count_d;
      lap_reg_q    <= lap_reg_d;
      lap_hold_q   <= lap_hold_d;
      dout         <= dout_d;
      running      <= (state_d == StRunning);
    end
  end

endmodule
